// File: rtl/demux1x8_buffered.sv
// Buffered 1:8 demultiplexer: steers one input word into one of eight lane
// registers, each with its own valid/ack handshake and a registered occupancy count.
module demux1x8_buffered #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [2:0]         in_select,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [8*WIDTH-1:0] out_data,
   output logic [7:0]         out_valid,
   input  logic [7:0]         out_ack,
   output logic [3:0]         out_count
);

   logic [7:0][WIDTH-1:0] data_p1;
   logic [7:0]            vld_p1;
   logic [3:0]            count_p1;

   logic                  accept_p0;
   logic [7:0]            load_p0;
   logic [7:0]            consume_p0;
   logic [7:0]            vld_nxt_p0;
   logic [3:0]            count_nxt_p0;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c = c + 4'(v[i]);
      end
      return c;
   endfunction

   // A lane may be written when empty or when its consumer drains it this cycle.
   assign in_ready = rst_n && (!vld_p1[in_select] || out_ack[in_select]);

   always_comb begin
      accept_p0    = in_valid && in_ready;
      load_p0      = accept_p0 ? (8'd1 << in_select) : 8'd0;
      consume_p0   = vld_p1 & out_ack;
      vld_nxt_p0   = (vld_p1 & ~consume_p0) | load_p0;
      count_nxt_p0 = popcount8(vld_nxt_p0);
   end

   // Stage p0 -> p1: lane registers, valid flags and occupancy count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_p1  <= '0;
         vld_p1   <= '0;
         count_p1 <= '0;
      end else begin
         vld_p1   <= vld_nxt_p0;
         count_p1 <= count_nxt_p0;
         if (accept_p0) begin
            data_p1[in_select] <= in_data;
         end
      end
   end

   assign out_data  = data_p1;
   assign out_valid = vld_p1;
   assign out_count = count_p1;

endmodule

// File: tb/tb_demux1x8_buffered.sv
// Directed plus randomized bench for demux1x8_buffered against a lane-array
// reference model; every comparison is an immediate assertion.
module tb_demux1x8_buffered;

   localparam int WIDTH = 32;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [WIDTH-1:0]   in_data = '0;
   logic [2:0]         in_select = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [8*WIDTH-1:0] out_data;
   logic [7:0]         out_valid;
   logic [7:0]         out_ack = '0;
   logic [3:0]         out_count;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: one word and one occupied flag per lane.
   logic [WIDTH-1:0] m_data [8];
   bit               m_full [8];
   bit               m_ready;

   demux1x8_buffered #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_select (in_select),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_valid();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_full[i];
      return v;
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 8; i++) if (m_full[i]) n++;
      return n;
   endfunction

   // One clock: drive inputs, check the combinational ready, clock the model,
   // then check every registered output half a cycle after the edge.
   task automatic step(input bit r, input bit v, input logic [2:0] s,
                       input logic [WIDTH-1:0] d, input logic [7:0] a);
      rst_n = r; in_valid = v; in_select = s; in_data = d; out_ack = a;
      #1;
      m_ready = r && (!m_full[s] || a[s]);
      chk("in_ready", WIDTH'(in_ready), WIDTH'(m_ready));
      @(posedge clk);
      if (!r) begin
         for (int i = 0; i < 8; i++) begin
            m_full[i] = 0;
            m_data[i] = '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) if (m_full[i] && a[i]) m_full[i] = 0;
         if (v && m_ready) begin
            m_data[s] = d;
            m_full[s] = 1;
         end
      end
      @(negedge clk);
      chk("out_valid", WIDTH'(out_valid), WIDTH'(model_valid()));
      chk("out_count", WIDTH'(out_count), WIDTH'(model_count()));
      for (int i = 0; i < 8; i++)
         chk($sformatf("lane%0d_data", i), out_data[i*WIDTH +: WIDTH], m_data[i]);
   endtask

   initial begin
      bit               cur_v;
      logic [2:0]       cur_s;
      logic [WIDTH-1:0] cur_d;
      logic [7:0]       cur_a;

      for (int i = 0; i < 8; i++) begin
         m_full[i] = 0;
         m_data[i] = '0;
      end
      @(negedge clk);

      // Reset held two cycles with a pending write to lane 3
      step(0, 1, 3'd3, 32'hDEAD_BEEF, 8'h00);
      step(0, 1, 3'd3, 32'hDEAD_BEEF, 8'h00);
      chk("rst_valid", WIDTH'(out_valid), 32'h0);
      chk("rst_count", WIDTH'(out_count), 32'h0);

      // Basic steer to lane 5
      step(1, 1, 3'd5, 32'hA5A5_0001, 8'h00);
      chk("steer_valid", WIDTH'(out_valid), 32'h20);
      chk("steer_lane5", out_data[5*WIDTH +: WIDTH], 32'hA5A5_0001);

      // Back-pressure on lane 2, then an unrelated write to lane 6
      step(1, 1, 3'd2, 32'h11, 8'h00);
      for (int k = 0; k < 5; k++) step(1, 1, 3'd2, 32'h22, 8'h00);
      chk("bp_lane2", out_data[2*WIDTH +: WIDTH], 32'h11);
      step(1, 1, 3'd6, 32'h66, 8'h00);
      chk("bp_count", WIDTH'(out_count), 32'd3);

      // Same-cycle consume and refill of lane 2
      step(1, 1, 3'd2, 32'h22, 8'h04);
      chk("refill_lane2", out_data[2*WIDTH +: WIDTH], 32'h22);
      chk("refill_count", WIDTH'(out_count), 32'd3);

      // Drain, then fill all eight lanes and drain them in one cycle
      step(1, 0, 3'd0, 32'h0, 8'hFF);
      for (int k = 0; k < 8; k++) step(1, 1, 3'(k), WIDTH'(k), 8'h00);
      chk("fill_valid", WIDTH'(out_valid), 32'hFF);
      chk("fill_count", WIDTH'(out_count), 32'd8);
      step(1, 0, 3'd0, 32'h0, 8'hFF);
      chk("drain_count", WIDTH'(out_count), 32'd0);
      chk("drain_lane7", out_data[7*WIDTH +: WIDTH], 32'd7);

      // Reset in the middle of operation with a write aimed at lane 4
      for (int k = 0; k < 4; k++) step(1, 1, 3'(k), 32'hC0 + WIDTH'(k), 8'h00);
      chk("pre_rst_valid", WIDTH'(out_valid), 32'h0F);
      step(0, 1, 3'd4, 32'h4444_4444, 8'h00);
      chk("midrst_lane4", out_data[4*WIDTH +: WIDTH], 32'h0);
      chk("midrst_count", WIDTH'(out_count), 32'd0);

      // Randomized traffic; a stalled producer holds its word until accepted
      cur_v = 0; cur_s = '0; cur_d = '0;
      for (int k = 0; k < 400; k++) begin
         if (!(cur_v && !m_ready) || k == 0) begin
            cur_v = ($urandom_range(0, 3) != 0);
            cur_s = 3'($urandom_range(0, 7));
            cur_d = WIDTH'($urandom);
         end
         cur_a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom & $urandom);
         step(($urandom_range(0, 63) != 0), cur_v, cur_s, cur_d, cur_a);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
